// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams.
// Define UART_TX_ARB_CKSUM_EN to append a modulo-256 checksum byte to every completed packet.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int GAP_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 pkt_done,
    output logic                 pkt_abort
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAP_W = (GAP_TIMEOUT > 0) ? $clog2(GAP_TIMEOUT + 1) : 1;

`ifdef UART_TX_ARB_CKSUM_EN
    typedef enum logic [2:0] {
        IDLE, FETCH, ISSUE, WAIT_ACK, WAIT_DONE, CK_ISSUE
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, FETCH, ISSUE, WAIT_ACK, WAIT_DONE
    } state_t;
`endif

    state_t           state;
    logic [IDX_W-1:0] gIdx;
    logic [IDX_W-1:0] lastGrant;
    logic [IDX_W-1:0] nextIdx;
    logic             nextFound;
    logic             lastFlag;
    logic [GAP_W-1:0] gapCnt;
    logic [7:0]       curByte;
    logic             curLast;
    logic             accept;
`ifdef UART_TX_ARB_CKSUM_EN
    logic [7:0]       acc;
    logic             ckSent;

    // Running packet checksum: 8-bit wrap, carries out of bit 7 are dropped.
    function automatic logic [7:0] cksumAdd(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction
`endif

    function automatic logic [NUM_REQ-1:0] oneHot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Nearest valid requester after lastGrant wins; scanning far-to-near lets the nearest overwrite.
    always_comb begin
        nextFound = 1'b0;
        nextIdx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid[(int'(lastGrant) + k) % NUM_REQ]) begin
                nextFound = 1'b1;
                nextIdx   = IDX_W'((int'(lastGrant) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        curByte = 8'h00;
        curLast = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gIdx == IDX_W'(i)) begin
                curByte = req_data[8*i +: 8];
                curLast = req_last[i];
            end
        end
    end

    assign accept = (state == FETCH) && ((req_valid & req_ready) != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            req_ready <= '0;
            gIdx      <= '0;
            lastGrant <= IDX_W'(NUM_REQ - 1);
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            pkt_done  <= 1'b0;
            pkt_abort <= 1'b0;
            lastFlag  <= 1'b0;
            gapCnt    <= '0;
`ifdef UART_TX_ARB_CKSUM_EN
            acc       <= 8'h00;
            ckSent    <= 1'b0;
`endif
        end else begin
            tx_start  <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (nextFound) begin
                        gIdx      <= nextIdx;
                        grant     <= oneHot(nextIdx);
                        req_ready <= oneHot(nextIdx);
                        gapCnt    <= '0;
                        lastFlag  <= 1'b0;
`ifdef UART_TX_ARB_CKSUM_EN
                        acc       <= 8'h00;
                        ckSent    <= 1'b0;
`endif
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (accept) begin
                        tx_data   <= curByte;
                        lastFlag  <= curLast;
`ifdef UART_TX_ARB_CKSUM_EN
                        acc       <= cksumAdd(acc, curByte);
`endif
                        req_ready <= '0;
                        gapCnt    <= '0;
                        state     <= ISSUE;
                    end else if (GAP_TIMEOUT != 0) begin
                        // Producer stalled mid-packet: abandon it so others are not starved.
                        if (int'(gapCnt) == GAP_TIMEOUT - 1) begin
                            pkt_abort <= 1'b1;
                            lastGrant <= gIdx;
                            grant     <= '0;
                            req_ready <= '0;
                            gapCnt    <= '0;
                            state     <= IDLE;
                        end else begin
                            gapCnt <= gapCnt + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        state    <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (!lastFlag) begin
                            req_ready <= grant;
                            gapCnt    <= '0;
                            state     <= FETCH;
                        end
`ifdef UART_TX_ARB_CKSUM_EN
                        else if (!ckSent) begin
                            state <= CK_ISSUE;
                        end
`endif
                        else begin
                            pkt_done  <= 1'b1;
                            lastGrant <= gIdx;
                            grant     <= '0;
                            state     <= IDLE;
                        end
                    end
                end
`ifdef UART_TX_ARB_CKSUM_EN
                CK_ISSUE: begin
                    tx_data <= acc;
                    ckSent  <= 1'b1;
                    state   <= ISSUE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transmitter model, per-requester byte producers and a scoreboard
// of expected {byte, grant} pairs checked on every tx_start.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int NREQ     = 4;
    localparam int GAPTO    = 8;
    localparam int BUSY_CYC = 20;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   grant;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic              pkt_done;
    logic              pkt_abort;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NREQ), .GAP_TIMEOUT(GAPTO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .grant(grant), .tx_start(tx_start),
        .tx_data(tx_data), .tx_busy(tx_busy), .pkt_done(pkt_done), .pkt_abort(pkt_abort)
    );

    // Transmitter: busy rises one cycle after start and holds for BUSY_CYC cycles.
    int busyCnt = 0;
    always @(posedge clk) begin
        if (busyCnt > 0) busyCnt <= busyCnt - 1;
        else if (tx_start) busyCnt <= BUSY_CYC;
    end
    assign tx_busy = (busyCnt != 0);

    typedef struct {
        logic [7:0] data;
        logic [3:0] grant;
    } expRec_t;

    typedef struct {
        int              req;
        int              len;
        logic [3:0][7:0] bytes;
        logic [7:0]      cksum;
        logic [3:0]      grantExp;
    } vec_t;

    expRec_t    expQ[$];
    vec_t       tbl [5];
    logic [7:0] prodData [NREQ][32];
    logic       prodLast [NREQ][32];
    int         prodHead [NREQ];
    int         prodTail [NREQ];
    int         total = 0;
    int         bad = 0;
    int         doneCount = 0;
    int         abortCount = 0;
    int         readyCycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic pushByte(input int r, input logic [7:0] d, input logic l);
        prodData[r][prodTail[r] % 32] = d;
        prodLast[r][prodTail[r] % 32] = l;
        prodTail[r]++;
    endtask

    task automatic expectByte(input logic [7:0] d, input logic [3:0] g);
        expRec_t e;
        e.data  = d;
        e.grant = g;
        expQ.push_back(e);
    endtask

    task automatic producer();
        logic [NREQ-1:0] pending = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (pending[i]) prodHead[i]++;
                if (prodHead[i] != prodTail[i]) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = prodData[i][prodHead[i] % 32];
                    req_last[i]        = prodLast[i][prodHead[i] % 32];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
                pending[i] = req_valid[i] & req_ready[i] & rst_n;
            end
        end
    endtask

    task automatic monitor();
        expRec_t e;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                readyCycles = 0;
                check("start_while_busy", 32'(tx_busy), 32'd0);
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_start: got data 0x%0h grant %b, required no start", tx_data, grant);
                end else begin
                    e = expQ.pop_front();
                    check("tx_data", 32'(tx_data), 32'(e.data));
                    check("tx_grant", 32'(grant), 32'(e.grant));
                end
            end else if (req_ready != '0) begin
                readyCycles++;
                check("ready_in_grant", 32'(req_ready & ~grant), 32'd0);
            end
            if (pkt_done) doneCount++;
            if (pkt_abort) abortCount++;
        end
    endtask

    task automatic waitDone(input int target, input string name);
        int n = 0;
        while (doneCount < target && n < 800) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, 32'(doneCount), 32'(target));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int d0;
        int a0;
        int n;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < NREQ; i++) begin
            prodHead[i] = 0;
            prodTail[i] = 0;
        end
        tbl[0] = '{2, 2, {8'h00, 8'h00, 8'h42, 8'h41}, 8'h83, 4'b0100};
        tbl[1] = '{1, 2, {8'h00, 8'h00, 8'h02, 8'hFF}, 8'h01, 4'b0010};
        tbl[2] = '{3, 3, {8'h00, 8'h01, 8'h80, 8'h80}, 8'h01, 4'b1000};
        tbl[3] = '{0, 4, {8'h40, 8'h30, 8'h20, 8'h10}, 8'hA0, 4'b0001};
        tbl[4] = '{2, 1, {8'h00, 8'h00, 8'h00, 8'h5A}, 8'h5A, 4'b0100};
        fork
            producer();
            monitor();
        join_none

        tick(3);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_pkt_done", 32'(pkt_done), 32'd0);
        check("rst_pkt_abort", 32'(pkt_abort), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Single-requester packets, one per table row.
        for (int t = 0; t < 5; t++) begin
            d0 = doneCount;
            for (int b = 0; b < tbl[t].len; b++) begin
                pushByte(tbl[t].req, tbl[t].bytes[b], b == tbl[t].len - 1);
                expectByte(tbl[t].bytes[b], tbl[t].grantExp);
            end
`ifdef UART_TX_ARB_CKSUM_EN
            expectByte(tbl[t].cksum, tbl[t].grantExp);
`endif
            waitDone(d0 + 1, "pkt_done_vec");
            tick(3);
            check("done_once_vec", 32'(doneCount), 32'(d0 + 1));
            check("grant_idle_vec", 32'(grant), 32'd0);
            check("drained_vec", 32'(expQ.size()), 32'd0);
        end

        // Round-robin from reset: all four hold packets, requester 0 has a second one queued.
        rst_n = 1'b0;
        d0 = doneCount;
        pushByte(0, 8'hA0, 1'b1);
        pushByte(0, 8'hB0, 1'b1);
        pushByte(1, 8'hA1, 1'b1);
        pushByte(2, 8'hA2, 1'b1);
        pushByte(3, 8'hA3, 1'b1);
        expectByte(8'hA0, 4'b0001);
`ifdef UART_TX_ARB_CKSUM_EN
        expectByte(8'hA0, 4'b0001);
`endif
        expectByte(8'hA1, 4'b0010);
`ifdef UART_TX_ARB_CKSUM_EN
        expectByte(8'hA1, 4'b0010);
`endif
        expectByte(8'hA2, 4'b0100);
`ifdef UART_TX_ARB_CKSUM_EN
        expectByte(8'hA2, 4'b0100);
`endif
        expectByte(8'hA3, 4'b1000);
`ifdef UART_TX_ARB_CKSUM_EN
        expectByte(8'hA3, 4'b1000);
`endif
        expectByte(8'hB0, 4'b0001);
`ifdef UART_TX_ARB_CKSUM_EN
        expectByte(8'hB0, 4'b0001);
`endif
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check("rr_first_grant", 32'(grant), 32'b0001);
        check("rr_first_ready", 32'(req_ready), 32'b0001);
        waitDone(d0 + 5, "rr_pkt_done");
        tick(3);
        check("rr_drained", 32'(expQ.size()), 32'd0);

        // Packet lock: requester 1 keeps the grant for all three bytes while 0 waits.
        d0 = doneCount;
        pushByte(1, 8'h11, 1'b0);
        pushByte(1, 8'h22, 1'b0);
        pushByte(1, 8'h33, 1'b1);
        pushByte(0, 8'h44, 1'b1);
        expectByte(8'h11, 4'b0010);
        expectByte(8'h22, 4'b0010);
        expectByte(8'h33, 4'b0010);
`ifdef UART_TX_ARB_CKSUM_EN
        expectByte(8'h66, 4'b0010);
`endif
        expectByte(8'h44, 4'b0001);
`ifdef UART_TX_ARB_CKSUM_EN
        expectByte(8'h44, 4'b0001);
`endif
        waitDone(d0 + 2, "lock_pkt_done");
        tick(3);
        check("lock_drained", 32'(expQ.size()), 32'd0);

        // Gap timeout: one non-last byte from requester 3, then silence.
        d0 = doneCount;
        a0 = abortCount;
        pushByte(3, 8'h55, 1'b0);
        expectByte(8'h55, 4'b1000);
        n = 0;
        while (abortCount == a0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("gap_abort_seen", 32'(abortCount), 32'(a0 + 1));
        check("gap_fetch_cycles", 32'(readyCycles), 32'(GAPTO));
        tick(30);
        check("gap_abort_once", 32'(abortCount), 32'(a0 + 1));
        check("gap_no_done", 32'(doneCount), 32'(d0));
        check("gap_grant_idle", 32'(grant), 32'd0);
        check("gap_no_cksum", 32'(expQ.size()), 32'd0);

        // Reset while a frame is on the wire; requester 0 still has a byte waiting.
        d0 = doneCount;
        pushByte(0, 8'hC1, 1'b0);
        pushByte(0, 8'hC2, 1'b1);
        expectByte(8'hC1, 4'b0001);
        expectByte(8'hC2, 4'b0001);
`ifdef UART_TX_ARB_CKSUM_EN
        expectByte(8'hC2, 4'b0001);
`endif
        n = 0;
        while (!tx_busy && n < 200) begin
            @(posedge clk);
            n++;
            #1;
        end
        check("rstmid_busy_seen", 32'(tx_busy), 32'd1);
        rst_n = 1'b0;
        tick(1);
        check("rstmid_grant_clr", 32'(grant), 32'd0);
        check("rstmid_no_start", 32'(tx_start), 32'd0);
        rst_n = 1'b1;
        tick(1);
        check("rstmid_regrant", 32'(grant), 32'b0001);
        waitDone(d0 + 1, "rstmid_pkt_done");
        tick(5);
        check("final_drained", 32'(expQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
